// File: rtl/seq_pair_multiplier.sv
// Sequential shift-add multiplier over a selected operand pair (A*B, B*C, C*D, D*A).
// Optional SEQ_MUL_SATURATE_EN: clamp the result to all-ones on overflow.
`ifndef WIDTH
`define WIDTH 8
`endif

module seq_pair_multiplier #(
    parameter int WIDTH = `WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   op_first;
    logic [WIDTH-1:0]   op_second;

    function automatic logic [WIDTH-1:0] result_f(input logic [2*WIDTH-1:0] prod);
`ifdef SEQ_MUL_SATURATE_EN
        if (|prod[2*WIDTH-1:WIDTH])
            return {WIDTH{1'b1}};
        else
            return prod[WIDTH-1:0];
`else
        return prod[WIDTH-1:0];
`endif
    endfunction

    // first operand of the pair is the multiplicand
    always_comb begin
        op_first  = A;
        op_second = B;
        case (select)
            2'b00: begin op_first = A; op_second = B; end
            2'b01: begin op_first = B; op_second = C; end
            2'b10: begin op_first = C; op_second = D; end
            2'b11: begin op_first = D; op_second = A; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = CALC;
            CALC: if (count == LAST_CNT) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // operand shift registers carry no reset: they are reloaded on every start
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mcand  <= {{WIDTH{1'b0}}, op_first};
            mplier <= op_second;
        end else if (state == CALC) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // DONE publishes on its exit edge, so done rises WIDTH+1 edges after start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            out      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    count <= count + CNT_W'(1);
                end
                DONE: begin
                    out      <= result_f(acc);
                    overflow <= |acc[2*WIDTH-1:WIDTH];
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pair_multiplier.sv
// Directed bench for seq_pair_multiplier: pair selection, latency, overflow,
// start filtering, back-to-back operation and asynchronous reset.
module tb_seq_pair_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A, B, C, D;
    logic [1:0] select;
    logic [7:0] out;
    logic       overflow;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_pair_multiplier dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .select   (select),
        .out      (out),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required end of test");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, then check latency, result and the return to idle.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [1:0] sel,
                          input logic [7:0] exp_out, input logic exp_ovf);
        int lat;
        int busy_cycles;
        @(negedge clk);
        A = a; B = b; C = c; D = d; select = sel; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy_start"}, busy, 1);
        lat = 0;
        busy_cycles = 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
        check_eq({tag, "_latency"}, lat, 9);
        check_eq({tag, "_out"}, out, exp_out);
        check_eq({tag, "_ovf"}, overflow, exp_ovf);
        check_eq({tag, "_busy_at_done"}, busy, 1);
        @(posedge clk); #1;
        check_eq({tag, "_busy_cycles"}, busy_cycles + 1, 10);
        check_eq({tag, "_done_low"}, done, 0);
        check_eq({tag, "_busy_low"}, busy, 0);
        check_eq({tag, "_out_held"}, out, exp_out);
    endtask

    logic [7:0] sat_400, sat_fe01, sat_256;
    int done_cnt;
    int first_done, second_done;
    int idle_seen;

    initial begin
`ifdef SEQ_MUL_SATURATE_EN
        sat_400  = 8'hFF;
        sat_fe01 = 8'hFF;
        sat_256  = 8'hFF;
`else
        sat_400  = 8'h90;
        sat_fe01 = 8'h01;
        sat_256  = 8'h00;
`endif
        rst = 1'b1; start = 1'b0;
        A = '0; B = '0; C = '0; D = '0; select = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", out, 0);
        check_eq("reset_ovf", overflow, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1_ab",   8'd12,  8'd10, 8'd0,   8'd0,   2'b00, 8'd120, 1'b0);
        run_op("t2_bc",   8'd0,   8'd20, 8'd20,  8'd0,   2'b01, sat_400, 1'b1);
        run_op("t3_cd",   8'd0,   8'd0,  8'd255, 8'd255, 2'b10, sat_fe01, 1'b1);
        run_op("t4_da0",  8'd200, 8'd0,  8'd0,   8'd0,   2'b11, 8'd0,   1'b0);
        run_op("t4b_da",  8'd15,  8'd99, 8'd77,  8'd16,  2'b11, 8'd240, 1'b0);
        run_op("bnd_256", 8'd16,  8'd16, 8'd0,   8'd0,   2'b00, sat_256, 1'b1);
        run_op("bnd_255", 8'd255, 8'd1,  8'd0,   8'd0,   2'b00, 8'd255, 1'b0);

        // Operand, select and start changes during CALC must not disturb the op.
        @(negedge clk);
        A = 8'd3; B = 8'd5; C = 8'd0; D = 8'd0; select = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("t5_out_steady_calc", out, 255);
        A = 8'd100; B = 8'd100; C = 8'd100; select = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("t5_done_pulses", done_cnt, 1);
        check_eq("t5_out", out, 15);
        check_eq("t5_ovf", overflow, 0);

        // Start held high: one operation every 10 cycles.
        @(negedge clk);
        A = 8'd3; B = 8'd5; select = 2'b00; start = 1'b1;
        first_done = 0; second_done = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (first_done == 0) first_done = i;
                else if (second_done == 0) second_done = i;
            end
        end
        check_eq("t5_b2b_first", first_done, 10);
        check_eq("t5_b2b_second", second_done, 20);
        check_eq("t5_b2b_out", out, 15);
        @(negedge clk);
        start = 1'b0;
        idle_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1;
                break;
            end
        end
        check_eq("t5_return_idle", idle_seen, 1);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        A = 8'd9; B = 8'd11; select = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_out", out, 0);
        check_eq("t6_rst_ovf", overflow, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t6_after", 8'd7, 8'd9, 8'd0, 8'd0, 2'b00, 8'd63, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
